bus_ack_rdmux: RTL and testbench
================================

Name: bus_ack_rdmux

Overview:
- Bus-cycle controller directly downstream of the address decoder.
- Consumes the per-region chip selects (lomem, pmon, himem, 16 IO slots, simif) for each CPU access.
- Inserts the region-dependent wait states and generates a single-cycle acknowledge.
- Multiplexes the selected slave's read data back to the CPU, and flags accesses that hit no region as bus errors.

Parameters:
- DW, 32, data bus width.
- MEM_LAT, 1, read latency in cycles of lomem/pmon/himem (synchronous RAM/ROM); range 0..15.
- IO_WAIT, 2, wait states for every IO/simif access, read or write; range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  CPU access strobe; held with wen/cs_* stable until ack.
- wen  in  1  1 = write, 0 = read.
- cs_lomem  in  1  from decoder.
- cs_pmon  in  1  from decoder.
- cs_himem  in  1  from decoder.
- cs_io  in  16  one-hot IO slot select, from decoder.
- cs_simif  in  1  from decoder.
- lomem_dout  in  DW  lomem read data.
- pmon_dout  in  DW  pmon read data.
- himem_dout  in  DW  himem read data.
- io_dout  in  DW  OR-combined IO read data; unselected peripherals drive 0.
- simif_dout  in  DW  simulator interface read data.
- cpu_wait  out  1  stall request to the CPU.
- ack  out  1  access complete, one-cycle pulse.
- err  out  1  unmapped access, valid with ack.
- rdata  out  DW  read data, valid with ack.

Behaviour:
- Reset values: state=IDLE, cnt=0, sel_q=NONE, ack=0, err=0, rdata=0.
- cpu_wait = req & ~ack (combinational).
- Source select, resolved at acceptance by priority simif > io (any cs_io bit) > pmon > lomem > himem > NONE.
  - The decoder guarantees at most one select; the priority only defines behaviour when more than one is asserted.
- Latency L, fixed at acceptance:
  - lomem/pmon/himem read: MEM_LAT.
  - lomem/pmon/himem write: 0.
  - simif/io, read or write: IO_WAIT.
  - NONE: 0.
- State machine: IDLE, BUSY, ACK.
  - IDLE & req: accept (cycle T); latch sel_q and err_q = (sel==NONE).
    - If L==0, go to ACK.
    - Otherwise go to BUSY with cnt=L.
  - BUSY: cnt decrements each cycle; when cnt==1, go to ACK. BUSY therefore lasts exactly L cycles.
  - ACK: ack=1 and err=err_q for exactly this one cycle (cycle T+L+1); next state is IDLE.
- ack and err are registered outputs derived from the state.
- Back-to-back accesses:
  - req still high in the ACK cycle belongs to the completing access.
  - A new access is accepted no earlier than the cycle after ACK.
  - Minimum access period is L+2 cycles.
- rdata:
  - When ack=1 and wen_q=0 and err_q=0: rdata is the dout of sel_q (combinational mux from registered sel_q).
  - Otherwise rdata=0, including on write acks and err acks.
- wen is latched as wen_q at acceptance.
- req dropping before ack (protocol violation): the transaction still runs to ACK; the ack pulse is emitted and ignored.
- cs_*/wen changes after acceptance are ignored; only the latched values count.
- Reset in any state: next cycle is IDLE with all outputs at reset values. An in-flight access is discarded with no ack.
- Counter: 4 bits; MEM_LAT/IO_WAIT values outside 0..15 are illegal.

Test Plan:
- Reset held 3 cycles with req=1 → ack=0, err=0, rdata=0 throughout; first ack at T+L+1 after reset release.
- MEM_LAT=1: lomem read, req at T, lomem_dout=32'hDEADBEEF.
  - Required: cpu_wait=1 at T and T+1.
  - Required: ack=1, rdata=32'hDEADBEEF, err=0 at T+2; cpu_wait=0 at T+2.
- Himem write, wen=1 → ack at T+1, rdata=0; next req accepted at T+2 and acked at T+3 for a pmon write.
- IO_WAIT=2: cs_io[15] read, io_dout=32'h0000_00A5 → ack only at T+3 with rdata=32'hA5.
  - Repeat with cs_simif: simif_dout=32'h1234 is returned, and io_dout=32'hFFFF is ignored.
- All cs_* low, read → ack=1, err=1, rdata=0 at T+1.
- IO_WAIT=5: assert reset during BUSY at T+2 → no ack at T+6; IDLE at T+3; a new lomem read issued afterwards completes normally.

Source files
------------

// File: rtl/bus_ack_rdmux.sv
`default_nettype none
// ============================================================================
// Module      : bus_ack_rdmux
// Description : Bus-cycle controller behind the address decoder. It latches
//               the selected region when an access is accepted and inserts
//               the wait states for that region. It then returns a one-cycle
//               ack, with err set for unmapped accesses, and muxes the
//               selected slave's read data to the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_ack_rdmux #(
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int IO_WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wen,
    input  logic          cs_lomem,
    input  logic          cs_pmon,
    input  logic          cs_himem,
    input  logic [15:0]   cs_io,
    input  logic          cs_simif,
    input  logic [DW-1:0] lomem_dout,
    input  logic [DW-1:0] pmon_dout,
    input  logic [DW-1:0] himem_dout,
    input  logic [DW-1:0] io_dout,
    input  logic [DW-1:0] simif_dout,
    output logic          cpu_wait,
    output logic          ack,
    output logic          err,
    output logic [DW-1:0] rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    localparam logic [2:0] c_SEL_NONE  = 3'd0;
    localparam logic [2:0] c_SEL_LOMEM = 3'd1;
    localparam logic [2:0] c_SEL_PMON  = 3'd2;
    localparam logic [2:0] c_SEL_HIMEM = 3'd3;
    localparam logic [2:0] c_SEL_IO    = 3'd4;
    localparam logic [2:0] c_SEL_SIMIF = 3'd5;

    // Latencies are held in the 4-bit wait counter, so only 0..15 are legal.
    localparam logic [3:0] c_MEM_LAT = 4'(MEM_LAT);
    localparam logic [3:0] c_IO_WAIT = 4'(IO_WAIT);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_accept;
    logic [2:0] w_sel;
    logic [3:0] w_lat;
    logic [2:0] r_sel_q;
    logic       r_wen_q;
    logic       r_err_q;
    logic       r_ack;

    // Source priority only matters if the decoder ever raises two selects.
    always_comb begin
        w_sel = c_SEL_NONE;
        if (cs_simif)      w_sel = c_SEL_SIMIF;
        else if (|cs_io)   w_sel = c_SEL_IO;
        else if (cs_pmon)  w_sel = c_SEL_PMON;
        else if (cs_lomem) w_sel = c_SEL_LOMEM;
        else if (cs_himem) w_sel = c_SEL_HIMEM;
    end

    // Wait states for the access being offered: memory writes complete at once.
    always_comb begin
        w_lat = 4'd0;
        case (w_sel)
            c_SEL_LOMEM, c_SEL_PMON, c_SEL_HIMEM: w_lat = wen ? 4'd0 : c_MEM_LAT;
            c_SEL_IO, c_SEL_SIMIF:                w_lat = c_IO_WAIT;
            default:                              w_lat = 4'd0;
        endcase
    end

    // Next-state logic: accept in IDLE, count down in BUSY, one cycle of ACK.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (w_lat == 4'd0) begin
                        w_state_nxt = c_ST_ACK;
                    end else begin
                        w_state_nxt = c_ST_BUSY;
                        w_cnt_nxt   = w_lat;
                    end
                end
            end
            c_ST_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_state_nxt = c_ST_ACK;
            end
            c_ST_ACK:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Transaction attributes frozen at acceptance; ack registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_q <= c_SEL_NONE;
            r_wen_q <= 1'b0;
            r_err_q <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= (w_state_nxt == c_ST_ACK);
            if (w_accept) begin
                r_sel_q <= w_sel;
                r_wen_q <= wen;
                r_err_q <= (w_sel == c_SEL_NONE);
            end
        end
    end

    assign ack      = r_ack;
    assign err      = r_ack & r_err_q;
    assign cpu_wait = req & ~r_ack;

    // Read data is only driven on a successful read ack, otherwise zero.
    always_comb begin
        rdata = '0;
        if (r_ack && !r_wen_q && !r_err_q) begin
            case (r_sel_q)
                c_SEL_LOMEM: rdata = lomem_dout;
                c_SEL_PMON:  rdata = pmon_dout;
                c_SEL_HIMEM: rdata = himem_dout;
                c_SEL_IO:    rdata = io_dout;
                c_SEL_SIMIF: rdata = simif_dout;
                default:     rdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_ack_rdmux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_ack_rdmux
// Description : Directed bench for bus_ack_rdmux. One instance uses the
//               default latencies. A second instance has IO_WAIT=5 and is used
//               for the reset-during-BUSY case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_ack_rdmux;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wen;
    logic        cs_lomem;
    logic        cs_pmon;
    logic        cs_himem;
    logic [15:0] cs_io;
    logic        cs_simif;
    logic [31:0] lomem_dout;
    logic [31:0] pmon_dout;
    logic [31:0] himem_dout;
    logic [31:0] io_dout;
    logic [31:0] simif_dout;

    logic        cpu_wait0, ack0, err0;
    logic [31:0] rdata0;
    logic        cpu_wait5, ack5, err5;
    logic [31:0] rdata5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_ack_rdmux #(.DW(32), .MEM_LAT(1), .IO_WAIT(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wen(wen),
        .cs_lomem(cs_lomem), .cs_pmon(cs_pmon), .cs_himem(cs_himem),
        .cs_io(cs_io), .cs_simif(cs_simif),
        .lomem_dout(lomem_dout), .pmon_dout(pmon_dout), .himem_dout(himem_dout),
        .io_dout(io_dout), .simif_dout(simif_dout),
        .cpu_wait(cpu_wait0), .ack(ack0), .err(err0), .rdata(rdata0)
    );

    bus_ack_rdmux #(.DW(32), .MEM_LAT(1), .IO_WAIT(5)) u_dut5 (
        .clk(clk), .reset(reset), .req(req), .wen(wen),
        .cs_lomem(cs_lomem), .cs_pmon(cs_pmon), .cs_himem(cs_himem),
        .cs_io(cs_io), .cs_simif(cs_simif),
        .lomem_dout(lomem_dout), .pmon_dout(pmon_dout), .himem_dout(himem_dout),
        .io_dout(io_dout), .simif_dout(simif_dout),
        .cpu_wait(cpu_wait5), .ack(ack5), .err(err5), .rdata(rdata5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cs();
        cs_lomem = 1'b0; cs_pmon = 1'b0; cs_himem = 1'b0;
        cs_io = 16'h0; cs_simif = 1'b0;
    endtask

    // Drives req from the start of cycle T (selects already set by the caller)
    // and expects stall for cycles T..T+lat, then ack in T+lat+1.
    task automatic run_access(input string tag, input bit use5, input int lat,
                              input logic [31:0] exp_rd, input logic exp_err);
        req = 1'b1;
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            check({tag, " wait"}, use5 ? cpu_wait5 : cpu_wait0, 1'b1);
            check({tag, " early ack"}, use5 ? ack5 : ack0, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check({tag, " ack"},   use5 ? ack5 : ack0, 1'b1);
        check({tag, " err"},   use5 ? err5 : err0, exp_err);
        check({tag, " rdata"}, use5 ? rdata5 : rdata0, exp_rd);
        check({tag, " wait at ack"}, use5 ? cpu_wait5 : cpu_wait0, 1'b0);
        req = 1'b0;
        clear_cs();
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = 1'b1; wen = 1'b0;
        clear_cs();
        cs_lomem   = 1'b1;
        lomem_dout = 32'hDEADBEEF;
        pmon_dout  = 32'h1111_2222;
        himem_dout = 32'h3333_4444;
        io_dout    = 32'h0000_00A5;
        simif_dout = 32'h0000_1234;

        // Reset held with req asserted: outputs stay at reset values.
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset ack",   ack0,   1'b0);
            check("reset err",   err0,   1'b0);
            check("reset rdata", rdata0, 32'h0);
            next_cycle();
        end
        reset = 1'b0;

        // Lomem read right after reset release, MEM_LAT=1: ack at T+2.
        run_access("lomem rd", 1'b0, 1, 32'hDEADBEEF, 1'b0);

        // Himem write acks at T+1 with zero rdata; pmon write back-to-back.
        wen = 1'b1; cs_himem = 1'b1;
        run_access("himem wr", 1'b0, 0, 32'h0, 1'b0);
        wen = 1'b1; cs_pmon = 1'b1;
        run_access("pmon wr", 1'b0, 0, 32'h0, 1'b0);

        // Pmon read returns pmon data after MEM_LAT.
        wen = 1'b0; cs_pmon = 1'b1;
        run_access("pmon rd", 1'b0, 1, 32'h1111_2222, 1'b0);

        // IO slot 15 read, IO_WAIT=2: ack at T+3.
        wen = 1'b0; cs_io = 16'h8000; io_dout = 32'h0000_00A5;
        run_access("io15 rd", 1'b0, 2, 32'h0000_00A5, 1'b0);

        // Simif wins over a concurrently asserted IO select; io data ignored.
        cs_simif = 1'b1; cs_io = 16'h0008; io_dout = 32'h0000_FFFF;
        run_access("simif rd", 1'b0, 2, 32'h0000_1234, 1'b0);

        // IO write also waits IO_WAIT cycles, rdata stays zero.
        wen = 1'b1; cs_io = 16'h0001;
        run_access("io wr", 1'b0, 2, 32'h0, 1'b0);

        // Unmapped read: err ack at T+1 with zero rdata.
        wen = 1'b0;
        run_access("unmapped", 1'b0, 0, 32'h0, 1'b1);

        // Change selects after acceptance: latched himem must be honoured.
        wen = 1'b0; cs_himem = 1'b1; req = 1'b1;
        @(negedge clk);
        check("latch wait", cpu_wait0, 1'b1);
        next_cycle();
        cs_himem = 1'b0; cs_simif = 1'b1; wen = 1'b1;
        @(negedge clk);
        check("latch busy ack", ack0, 1'b0);
        next_cycle();
        @(negedge clk);
        check("latch ack",   ack0,   1'b1);
        check("latch rdata", rdata0, 32'h3333_4444);
        req = 1'b0; wen = 1'b0;
        clear_cs();
        next_cycle();

        // IO_WAIT=5 instance: reset in the BUSY cycle T+2 aborts the access.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        cs_io = 16'h0100; req = 1'b1;      // cycle T
        next_cycle();                      // T+1
        next_cycle();                      // T+2
        reset = 1'b1; req = 1'b0;
        clear_cs();
        next_cycle();                      // T+3
        reset = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            @(negedge clk);
            check("abort no ack", ack5, 1'b0);
            check("abort no wait", cpu_wait5, 1'b0);
            next_cycle();
        end
        cs_lomem = 1'b1; wen = 1'b0; lomem_dout = 32'hCAFE_0001;
        run_access("post-abort lomem", 1'b1, 1, 32'hCAFE_0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
